// File: rtl/calculator_simulation_ver.sv
// Four-digit BCD calculator with multiplexed seven-segment display.
// Two 2-digit operands are entered with per-digit increment keys; an op key
// selects add, absolute difference, multiply, divide or an operand readout.
// The selected result is shown in decimal on four time-multiplexed digits.
module calculator_simulation_ver #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        resetButton,
  input  logic [8:0]  buttons,
  output logic [7:0]  ss,
  output logic [3:0]  enables,
  output logic [13:0] result,
  output logic [7:0]  number1,
  output logic [7:0]  number2
);

  typedef enum logic [2:0] {
    MODE_SHOW,
    MODE_ADD,
    MODE_SUB,
    MODE_MUL,
    MODE_DIV
  } mode_t;

  // digit_q[0] = D1 (number2 ones) ... digit_q[3] = D4 (number1 tens)
  logic [3:0]              digit_q [4];
  logic [3:0]              digit_d [4];
  logic [3:0]              btn_prev_q;
  logic                    armed_q;
  mode_t                   mode_q;
  mode_t                   mode_d;
  logic [REFRESH_BITS-1:0] refresh_q;

  logic [3:0]  digit_rise;
  logic        neg;
  logic [1:0]  slot;
  logic [13:0] q10;
  logic [13:0] q100;
  logic [13:0] q1000;
  logic [13:0] rem_ones;
  logic [13:0] rem_tens;
  logic [13:0] rem_hund;
  logic [13:0] rem_thou;
  logic [3:0]  disp_digit;

  // Rising edges on digit keys. The first cycle after reset only loads the
  // history, so a key already held when reset releases is not a new press.
  assign digit_rise = buttons[3:0] & ~btn_prev_q & {4{armed_q}};

  // Each digit wraps 9 -> 0 on its own key edge, independently of the others.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      // Next value of one BCD digit
      always_comb begin
        digit_d[gi] = digit_q[gi];
        if (digit_rise[gi]) begin
          digit_d[gi] = (digit_q[gi] == 4'd9) ? 4'd0 : digit_q[gi] + 4'd1;
        end
      end
    end
  endgenerate

  // Mode selection: level-sensitive op keys, lowest index has priority
  always_comb begin
    mode_d = mode_q;
    if (buttons[4])      mode_d = MODE_ADD;
    else if (buttons[5]) mode_d = MODE_SUB;
    else if (buttons[6]) mode_d = MODE_MUL;
    else if (buttons[7]) mode_d = MODE_DIV;
    else if (buttons[8]) mode_d = MODE_SHOW;
  end

  // State registers: digits, mode, key history, arm flag and refresh counter
  always_ff @(posedge clk or negedge resetButton) begin
    if (!resetButton) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
      mode_q     <= MODE_SHOW;
      btn_prev_q <= 4'd0;
      armed_q    <= 1'b0;
      refresh_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
      mode_q     <= mode_d;
      btn_prev_q <= buttons[3:0];
      armed_q    <= 1'b1;
      refresh_q  <= refresh_q + 1'b1;
    end
  end

  assign number1 = {4'd0, digit_q[3]} * 8'd10 + {4'd0, digit_q[2]};
  assign number2 = {4'd0, digit_q[1]} * 8'd10 + {4'd0, digit_q[0]};
  assign neg     = (mode_q == MODE_SUB) && (number1 < number2);

  // Arithmetic result for the current mode; divide by zero yields 0
  always_comb begin
    result = 14'd0;
    case (mode_q)
      MODE_ADD:  result = {6'd0, number1} + {6'd0, number2};
      MODE_SUB:  result = neg ? {6'd0, number2 - number1}
                              : {6'd0, number1 - number2};
      MODE_MUL:  result = {6'd0, number1} * {6'd0, number2};
      MODE_DIV:  result = (number2 == 8'd0) ? 14'd0
                                            : {6'd0, number1 / number2};
      default:   result = {6'd0, number1} * 14'd100 + {6'd0, number2};
    endcase
  end

  // Decimal digit extraction of the result (leading zeros kept)
  always_comb begin
    q10      = result / 14'd10;
    q100     = result / 14'd100;
    q1000    = result / 14'd1000;
    rem_ones = result - q10 * 14'd10;
    rem_tens = q10 - q100 * 14'd10;
    rem_hund = q100 - q1000 * 14'd10;
    rem_thou = q1000 % 14'd10;
  end

  assign slot = refresh_q[REFRESH_BITS-1 -: 2];

  // Active-low {dp,g,f,e,d,c,b,a} pattern for a decimal digit
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'b1100_0000;
      4'd1:    seg7 = 8'b1111_1001;
      4'd2:    seg7 = 8'b1010_0100;
      4'd3:    seg7 = 8'b1011_0000;
      4'd4:    seg7 = 8'b1001_1001;
      4'd5:    seg7 = 8'b1001_0010;
      4'd6:    seg7 = 8'b1000_0010;
      4'd7:    seg7 = 8'b1111_1000;
      4'd8:    seg7 = 8'b1000_0000;
      4'd9:    seg7 = 8'b1001_0000;
      default: seg7 = 8'b1111_1111;
    endcase
  endfunction

  // Display multiplexer: one anode per slot, minus sign replaces thousands
  always_comb begin
    enables = ~(4'b0001 << slot);
    case (slot)
      2'd0:    disp_digit = rem_ones[3:0];
      2'd1:    disp_digit = rem_tens[3:0];
      2'd2:    disp_digit = rem_hund[3:0];
      default: disp_digit = rem_thou[3:0];
    endcase
    ss = seg7(disp_digit);
    if (slot == 2'd3 && neg) ss = 8'b1011_1111;
  end

endmodule

// File: tb/tb_calculator_simulation_ver.sv
// Directed bench for the calculator: operand entry, all modes, wrap,
// display digits, minus sign, divide by zero, key hold and reset behaviour.
module tb_calculator_simulation_ver;

  logic        clk;
  logic        resetButton;
  logic [8:0]  buttons;
  logic [7:0]  ss;
  logic [3:0]  enables;
  logic [13:0] result;
  logic [7:0]  number1;
  logic [7:0]  number2;

  int checks = 0;
  int passes = 0;

  calculator_simulation_ver #(.REFRESH_BITS(4)) dut (
    .clk         (clk),
    .resetButton (resetButton),
    .buttons     (buttons),
    .ss          (ss),
    .enables     (enables),
    .result      (result),
    .number1     (number1),
    .number2     (number2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
      $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int k);
    @(negedge clk) buttons[k] = 1'b1;
    @(negedge clk) buttons[k] = 1'b0;
  endtask

  task automatic press_n(input int k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  // Wait (bounded) for a given anode pattern, then check the segments
  task automatic chk_disp(input string tag, input logic [3:0] en, input logic [7:0] exp_ss);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (enables === en) found = 1;
    end
    if (!found) chk({tag, "_timeout"}, {28'd0, enables}, {28'd0, en});
    else chk(tag, {24'd0, ss}, {24'd0, exp_ss});
  endtask

  initial begin
    resetButton = 1'b0;
    buttons     = 9'd0;
    repeat (3) @(negedge clk);
    chk("rst_n1", number1, 0);
    chk("rst_n2", number2, 0);
    chk("rst_res", result, 0);
    chk("rst_en", enables, 4'b1110);
    chk("rst_ss", ss, 8'b1100_0000);
    @(negedge clk) resetButton = 1'b1;

    // all digits to 9
    for (int k = 0; k < 4; k++) press_n(k, 9);
    chk("n1_99", number1, 99);
    chk("n2_99", number2, 99);
    press(8); chk("show_9999", result, 9999);
    chk_disp("ss_thou_9", 4'b0111, 8'b1001_0000);
    press(4); chk("add_198", result, 198);
    press(6); chk("mul_9801", result, 9801);
    press(5); chk("sub_0", result, 0);
    press(7); chk("div_1", result, 1);

    // D1 wraps to 8
    press_n(0, 9);
    chk("n2_98", number2, 98);
    press(8); chk("show_9998", result, 9998);
    press(5); chk("sub_1", result, 1);
    press(7); chk("div_1b", result, 1);

    // number1 = 32
    press_n(3, 4);
    press_n(2, 3);
    chk("n1_32", number1, 32);
    press(8); chk("show_3298", result, 3298);
    press(5); chk("sub_66", result, 66);
    chk_disp("ss_minus", 4'b0111, 8'b1011_1111);
    chk_disp("ss_66_ones", 4'b1110, 8'b1000_0010);
    chk_disp("ss_66_hund", 4'b1011, 8'b1100_0000);
    press(7); chk("div_0", result, 0);
    press(6); chk("mul_3136", result, 3136);
    chk_disp("ss_3136_u", 4'b1110, 8'b1000_0010);
    chk_disp("ss_3136_t", 4'b1101, 8'b1011_0000);
    chk_disp("ss_3136_h", 4'b1011, 8'b1111_1001);
    chk_disp("ss_3136_k", 4'b0111, 8'b1011_0000);

    // number2 = 10
    press_n(0, 2);
    press_n(1, 2);
    chk("n2_10", number2, 10);
    press(8); chk("show_3210", result, 3210);
    press(7); chk("div_3", result, 3);

    // priority: ADD and SUB together -> ADD; mode persists after release
    @(negedge clk) buttons[5:4] = 2'b11;
    @(negedge clk) buttons[5:4] = 2'b00;
    @(negedge clk);
    chk("prio_add", result, 42);

    // simultaneous digit keys D1 and D4
    @(negedge clk) buttons[3:0] = 4'b1001;
    @(negedge clk) buttons[3:0] = 4'b0000;
    chk("simul_n1", number1, 42);
    chk("simul_n2", number2, 11);

    // number2 = 0, divide by zero
    press_n(1, 9);
    press_n(0, 9);
    chk("n2_0", number2, 0);
    press(7); chk("div_by_0", result, 0);

    // held key increments once
    @(negedge clk) buttons[0] = 1'b1;
    repeat (10) @(negedge clk);
    buttons[0] = 1'b0;
    chk("hold_once", number2, 1);

    // asynchronous reset mid-cycle
    @(negedge clk);
    #2 resetButton = 1'b0;
    #1;
    chk("arst_n1", number1, 0);
    chk("arst_n2", number2, 0);
    chk("arst_res", result, 0);
    chk("arst_en", enables, 4'b1110);
    chk("arst_ss", ss, 8'b1100_0000);

    // presses during reset ignored; held key at release is not an edge
    @(negedge clk) buttons[1] = 1'b1;
    @(negedge clk) buttons[1] = 1'b0;
    buttons[0] = 1'b1;
    @(negedge clk) resetButton = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_rel_n2", number2, 0);
    buttons[0] = 1'b0;
    press(0);
    chk("repress_n2", number2, 1);
    chk("repress_mode", result, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
